// File: rtl/cmt_trace_buf.sv
// cmt_trace_buf: commit-stream trace buffer.
// Records the last DEPTH committed instructions from the writeback/difftest
// commit stream into a ring buffer. Capture stops on a trap instruction or an
// external freeze, after which a debug master drains the recorded entries
// oldest-first through a show-ahead valid/ready port.

module cmt_trace_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmtvalid,
    input  logic             i_skipcmt,
    input  logic [63:0]      i_pc,
    input  logic [31:0]      i_inst,
    input  logic [4:0]       i_rd,
    input  logic             i_rd_wen,
    input  logic [63:0]      i_rd_wdata,
    input  logic [31:0]      i_intrNo,
    input  logic [7:0]       i_trap_code,
    input  logic             i_freeze,
    input  logic             i_clear,
    input  logic             i_rd_ready,
    output logic             o_rd_valid,
    output logic [63:0]      o_rd_pc,
    output logic [31:0]      o_rd_inst,
    output logic             o_rd_wen,
    output logic [4:0]       o_rd_wdest,
    output logic [63:0]      o_rd_wdata,
    output logic             o_rd_skip,
    output logic [AW:0]      o_count,
    output logic             o_overflow,
    output logic             o_halted,
    output logic             o_trap,
    output logic [7:0]       o_trap_code,
    output logic [63:0]      o_trap_pc,
    output logic [63:0]      o_cycle_cnt,
    output logic [63:0]      o_instr_cnt
);

    // Capture runs in ST_RUN; ST_HALT freezes the buffer for draining.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // One trace record as stored in the ring.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic        skip;
    } entry_t;

    localparam logic [6:0]    TRAP_OPCODE = 7'h6b;
    localparam logic [AW-1:0] PTR_ZERO    = AW'(0);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [AW:0]   CNT_ZERO    = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_ONE     = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL    = (AW + 1)'(DEPTH);
    localparam logic [63:0]   CTR_ZERO    = 64'd0;
    localparam logic [63:0]   CTR_ONE     = 64'd1;
    localparam logic [31:0]   INTR_NONE   = 32'd0;

    // Architectural state.
    state_t        state_q;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          trap_q;
    logic [7:0]    trap_code_q;
    logic [63:0]   trap_pc_q;
    logic [63:0]   cycle_cnt_q;
    logic [63:0]   instr_cnt_q;

    // Trace storage; deliberately not reset, validity is tracked by count_q.
    entry_t        mem_q [DEPTH];

    // Per-cycle decode.
    logic          in_run_s;
    logic          in_halt_s;
    logic          full_s;
    logic          capture_s;
    logic          trap_s;
    logic          rd_valid_s;
    logic          pop_s;
    entry_t        wr_entry_s;
    entry_t        head_s;

    // Decode capture, trap and pop conditions; clear suppresses both capture and pop.
    always_comb begin
        in_run_s   = (state_q == ST_RUN);
        in_halt_s  = (state_q == ST_HALT);
        full_s     = (count_q == CNT_FULL);
        capture_s  = in_run_s && i_cmtvalid && (i_intrNo == INTR_NONE) && !i_clear;
        trap_s     = capture_s && (i_inst[6:0] == TRAP_OPCODE);
        rd_valid_s = in_halt_s && (count_q != CNT_ZERO);
        pop_s      = rd_valid_s && i_rd_ready && !i_clear;
    end

    // Assemble the record written on capture.
    always_comb begin
        wr_entry_s.pc    = i_pc;
        wr_entry_s.inst  = i_inst;
        wr_entry_s.wen   = i_rd_wen;
        wr_entry_s.rd    = i_rd;
        wr_entry_s.wdata = i_rd_wdata;
        wr_entry_s.skip  = i_skipcmt;
    end

    // Ring storage write port: one record per captured commit at the write pointer.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            mem_q[wptr_q] <= wr_entry_s;
        end
    end

    // Control: FSM, pointers, occupancy, sticky trap/overflow flags and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wptr_q      <= PTR_ZERO;
            rptr_q      <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            overflow_q  <= 1'b0;
            trap_q      <= 1'b0;
            trap_code_q <= 8'h00;
            trap_pc_q   <= CTR_ZERO;
            cycle_cnt_q <= CTR_ZERO;
            instr_cnt_q <= CTR_ZERO;
        end else begin
            // The run-time counter advances in RUN regardless of clear.
            if (in_run_s) begin
                cycle_cnt_q <= cycle_cnt_q + CTR_ONE;
            end else begin
                cycle_cnt_q <= cycle_cnt_q;
            end

            if (i_clear) begin
                // Flush wins over any same-cycle commit, pop or trap.
                wptr_q      <= PTR_ZERO;
                rptr_q      <= PTR_ZERO;
                count_q     <= CNT_ZERO;
                overflow_q  <= 1'b0;
                trap_q      <= 1'b0;
                trap_code_q <= 8'h00;
                trap_pc_q   <= CTR_ZERO;
                if (i_freeze) begin
                    state_q <= ST_HALT;
                end else begin
                    state_q <= ST_RUN;
                end
            end else begin
                // Capture and pop are mutually exclusive: capture needs RUN, pop needs HALT.
                if (capture_s) begin
                    wptr_q      <= wptr_q + PTR_ONE;
                    instr_cnt_q <= instr_cnt_q + CTR_ONE;
                    if (full_s) begin
                        // Oldest record is overwritten; keep the read side on the new oldest.
                        rptr_q     <= rptr_q + PTR_ONE;
                        overflow_q <= 1'b1;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end else if (pop_s) begin
                    rptr_q  <= rptr_q + PTR_ONE;
                    count_q <= count_q - CNT_ONE;
                end else begin
                    rptr_q  <= rptr_q;
                    count_q <= count_q;
                end

                if (trap_s) begin
                    trap_q      <= 1'b1;
                    trap_code_q <= i_trap_code;
                    trap_pc_q   <= i_pc;
                end

                case (state_q)
                    ST_RUN: begin
                        if (trap_s || i_freeze) begin
                            state_q <= ST_HALT;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_HALT: begin
                        state_q <= ST_HALT;
                    end
                    default: begin
                        state_q <= ST_RUN;
                    end
                endcase
            end
        end
    end

    // Show-ahead read of the oldest held record.
    always_comb begin
        head_s = mem_q[rptr_q];
    end

    // Drain port and status outputs, all derived directly from registered state.
    always_comb begin
        o_rd_valid  = rd_valid_s;
        o_rd_pc     = head_s.pc;
        o_rd_inst   = head_s.inst;
        o_rd_wen    = head_s.wen;
        o_rd_wdest  = head_s.rd;
        o_rd_wdata  = head_s.wdata;
        o_rd_skip   = head_s.skip;
        o_count     = count_q;
        o_overflow  = overflow_q;
        o_halted    = in_halt_s;
        o_trap      = trap_q;
        o_trap_code = trap_code_q;
        o_trap_pc   = trap_pc_q;
        o_cycle_cnt = cycle_cnt_q;
        o_instr_cnt = instr_cnt_q;
    end

endmodule

// File: tb/tb_cmt_trace_buf.sv
// Self-checking bench for cmt_trace_buf: directed scenarios followed by a
// randomized run, every output compared each cycle against a queue-based
// reference model of the trace buffer.

module tb_cmt_trace_buf;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmtvalid;
    logic          i_skipcmt;
    logic [63:0]   i_pc;
    logic [31:0]   i_inst;
    logic [4:0]    i_rd;
    logic          i_rd_wen;
    logic [63:0]   i_rd_wdata;
    logic [31:0]   i_intrNo;
    logic [7:0]    i_trap_code;
    logic          i_freeze;
    logic          i_clear;
    logic          i_rd_ready;
    logic          o_rd_valid;
    logic [63:0]   o_rd_pc;
    logic [31:0]   o_rd_inst;
    logic          o_rd_wen;
    logic [4:0]    o_rd_wdest;
    logic [63:0]   o_rd_wdata;
    logic          o_rd_skip;
    logic [AW:0]   o_count;
    logic          o_overflow;
    logic          o_halted;
    logic          o_trap;
    logic [7:0]    o_trap_code;
    logic [63:0]   o_trap_pc;
    logic [63:0]   o_cycle_cnt;
    logic [63:0]   o_instr_cnt;

    always #5 clk = ~clk;

    cmt_trace_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmtvalid  (i_cmtvalid),
        .i_skipcmt   (i_skipcmt),
        .i_pc        (i_pc),
        .i_inst      (i_inst),
        .i_rd        (i_rd),
        .i_rd_wen    (i_rd_wen),
        .i_rd_wdata  (i_rd_wdata),
        .i_intrNo    (i_intrNo),
        .i_trap_code (i_trap_code),
        .i_freeze    (i_freeze),
        .i_clear     (i_clear),
        .i_rd_ready  (i_rd_ready),
        .o_rd_valid  (o_rd_valid),
        .o_rd_pc     (o_rd_pc),
        .o_rd_inst   (o_rd_inst),
        .o_rd_wen    (o_rd_wen),
        .o_rd_wdest  (o_rd_wdest),
        .o_rd_wdata  (o_rd_wdata),
        .o_rd_skip   (o_rd_skip),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_halted    (o_halted),
        .o_trap      (o_trap),
        .o_trap_code (o_trap_code),
        .o_trap_pc   (o_trap_pc),
        .o_cycle_cnt (o_cycle_cnt),
        .o_instr_cnt (o_instr_cnt)
    );

    // Reference model: the buffer is just a queue of the most recent records.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic        skip;
    } ent_t;

    ent_t        m_q[$];
    bit          m_halt;
    bit          m_ovf;
    bit          m_trap;
    logic [7:0]  m_tcode;
    logic [63:0] m_tpc;
    logic [63:0] m_cyc;
    logic [63:0] m_icnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit   was_halt;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_halt = 1'b0; m_ovf = 1'b0; m_trap = 1'b0;
            m_tcode = 8'h00; m_tpc = 64'd0; m_cyc = 64'd0; m_icnt = 64'd0;
            return;
        end
        was_halt = m_halt;
        if (!was_halt) m_cyc = m_cyc + 64'd1;
        if (i_clear) begin
            m_q.delete();
            m_ovf = 1'b0; m_trap = 1'b0; m_tcode = 8'h00; m_tpc = 64'd0;
            m_halt = i_freeze;
        end else begin
            if (!was_halt && i_cmtvalid && i_intrNo == 32'd0) begin
                e.pc = i_pc; e.inst = i_inst; e.wen = i_rd_wen;
                e.rd = i_rd; e.wdata = i_rd_wdata; e.skip = i_skipcmt;
                m_q.push_back(e);
                m_icnt = m_icnt + 64'd1;
                if (m_q.size() > DEPTH) begin
                    void'(m_q.pop_front());
                    m_ovf = 1'b1;
                end
                if (i_inst[6:0] == 7'h6b) begin
                    m_trap = 1'b1; m_tcode = i_trap_code; m_tpc = i_pc; m_halt = 1'b1;
                end
            end
            if (!was_halt && i_freeze) m_halt = 1'b1;
            if (was_halt && m_q.size() != 0 && i_rd_ready) void'(m_q.pop_front());
        end
    endtask

    task automatic check_all();
        bit exp_valid;
        exp_valid = m_halt && (m_q.size() != 0);
        chk("count",     64'(o_count),     64'(m_q.size()));
        chk("halted",    64'(o_halted),    64'(m_halt));
        chk("rd_valid",  64'(o_rd_valid),  64'(exp_valid));
        chk("overflow",  64'(o_overflow),  64'(m_ovf));
        chk("trap",      64'(o_trap),      64'(m_trap));
        chk("trap_code", 64'(o_trap_code), 64'(m_tcode));
        chk("trap_pc",   o_trap_pc,        m_tpc);
        chk("cycle_cnt", o_cycle_cnt,      m_cyc);
        chk("instr_cnt", o_instr_cnt,      m_icnt);
        if (exp_valid) begin
            chk("head_pc",    o_rd_pc,           m_q[0].pc);
            chk("head_inst",  64'(o_rd_inst),    64'(m_q[0].inst));
            chk("head_wen",   64'(o_rd_wen),     64'(m_q[0].wen));
            chk("head_wdest", 64'(o_rd_wdest),   64'(m_q[0].rd));
            chk("head_wdata", o_rd_wdata,        m_q[0].wdata);
            chk("head_skip",  64'(o_rd_skip),    64'(m_q[0].skip));
        end
    endtask

    // One clock: update model, take the edge, sample away from it, compare.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        i_cmtvalid = 1'b0; i_skipcmt = 1'b0; i_pc = 64'd0; i_inst = 32'd0;
        i_rd = 5'd0; i_rd_wen = 1'b0; i_rd_wdata = 64'd0; i_intrNo = 32'd0;
        i_trap_code = 8'h00; i_freeze = 1'b0; i_clear = 1'b0; i_rd_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        v = $urandom;
        if (v[6:0] == 7'h6b) v[0] = ~v[0];
        return v;
    endfunction

    task automatic set_commit(input logic [63:0] pc, input logic [31:0] inst);
        i_cmtvalid = 1'b1; i_pc = pc; i_inst = inst;
        i_rd = 5'($urandom); i_rd_wen = 1'($urandom); i_skipcmt = 1'($urandom);
        i_rd_wdata = {32'($urandom), 32'($urandom)};
        i_trap_code = 8'($urandom);
    endtask

    task automatic commit(input logic [63:0] pc, input logic [31:0] inst);
        set_commit(pc, inst);
        cycle();
        idle();
    endtask

    task automatic freeze_cycle();
        idle(); i_freeze = 1'b1; cycle(); idle();
    endtask

    task automatic clear_cycle();
        idle(); i_clear = 1'b1; cycle(); idle();
    endtask

    initial begin
        logic [63:0] saved;
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_count", 64'(o_count), 64'd0);
        chk("reset_valid", 64'(o_rd_valid), 64'd0);

        // Five commits, freeze, drain in order.
        for (int k = 0; k < 5; k++) commit(64'h8000_0000 + 64'(4 * k), rand_inst());
        freeze_cycle();
        chk("t1_count", 64'(o_count), 64'd5);
        chk("t1_halted", 64'(o_halted), 64'd1);
        i_rd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t1_drain_pc", o_rd_pc, 64'h8000_0000 + 64'(4 * k));
            cycle();
        end
        chk("t1_valid_drop", 64'(o_rd_valid), 64'd0);
        clear_cycle();

        // Overflow: 20 commits into 16 entries.
        for (int k = 0; k < 20; k++) commit(64'(k), rand_inst());
        freeze_cycle();
        chk("t2_count", 64'(o_count), 64'd16);
        chk("t2_overflow", 64'(o_overflow), 64'd1);
        chk("t2_first_pc", o_rd_pc, 64'd4);
        i_rd_ready = 1'b1;
        for (int k = 0; k < 15; k++) cycle();
        chk("t2_last_pc", o_rd_pc, 64'd19);
        cycle();
        clear_cycle();

        // Trap after three commits halts capture and freezes the cycle counter.
        for (int k = 0; k < 3; k++) commit(64'h8000_00f0 + 64'(4 * k), rand_inst());
        set_commit(64'h8000_0100, 32'h0000_006b);
        i_trap_code = 8'h00;
        cycle();
        idle();
        chk("t3_trap", 64'(o_trap), 64'd1);
        chk("t3_trap_pc", o_trap_pc, 64'h8000_0100);
        chk("t3_count", 64'(o_count), 64'd4);
        chk("t3_halted", 64'(o_halted), 64'd1);
        saved = m_cyc;
        commit(64'h8000_0104, rand_inst());
        chk("t3_cycle_frozen", o_cycle_cnt, saved);
        chk("t3_count_after", 64'(o_count), 64'd4);
        clear_cycle();

        // Interrupt cycle is not captured.
        saved = m_icnt;
        set_commit(64'h8000_0200, rand_inst());
        i_intrNo = 32'd7;
        cycle();
        idle();
        chk("t4_intr_count", 64'(o_count), 64'd0);
        commit(64'h8000_0204, rand_inst());
        chk("t4_instr_cnt", o_instr_cnt, saved + 64'd1);

        // Two entries held in HALT, ready stalls then toggles.
        set_commit(64'h8000_0208, rand_inst());
        i_freeze = 1'b1;
        cycle();
        idle();
        chk("t5_count", 64'(o_count), 64'd2);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_stall_pc", o_rd_pc, 64'h8000_0204);
        end
        for (int k = 0; k < 4; k++) begin
            i_rd_ready = (k % 2 == 0);
            cycle();
        end
        chk("t5_drained", 64'(o_count), 64'd0);
        idle();

        // Clear in HALT with six entries and a same-cycle commit.
        clear_cycle();
        for (int k = 0; k < 6; k++) commit(64'h8000_0300 + 64'(4 * k), rand_inst());
        freeze_cycle();
        saved = m_icnt;
        set_commit(64'h8000_0400, rand_inst());
        i_clear = 1'b1;
        cycle();
        idle();
        chk("t6_count", 64'(o_count), 64'd0);
        chk("t6_halted", 64'(o_halted), 64'd0);
        chk("t6_instr_cnt", o_instr_cnt, saved);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            idle();
            if ($urandom_range(3, 0) != 0) begin
                if ($urandom_range(39, 0) == 0)
                    set_commit({32'($urandom), 32'($urandom)}, {25'($urandom), 7'h6b});
                else
                    set_commit({32'($urandom), 32'($urandom)}, rand_inst());
            end
            if ($urandom_range(9, 0) == 0) i_intrNo = 32'($urandom_range(255, 1));
            i_freeze   = ($urandom_range(29, 0) == 0);
            i_clear    = ($urandom_range(24, 0) == 0);
            i_rd_ready = 1'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmt_trace_buf.md
Name: cmt_trace_buf

Overview:
- Receives the per-instruction commit stream that the writeback stage drives toward difftest: pc, inst, rd write, interrupt number, skip.
- Captures valid commits into a DEPTH-entry ring trace buffer.
- Halts capture on a trap instruction (opcode 7'h6b) or on an external freeze.
- Exposes a valid/ready drain port so a debug master can read the last DEPTH commits in order, oldest first.

Parameters:
- DEPTH, 16, number of trace entries; must be a power of two, at least 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- i_cmtvalid  in  1  commit valid this cycle
- i_skipcmt  in  1  commit is a skip (MMIO etc.)
- i_pc  in  64  committed pc
- i_inst  in  32  committed instruction
- i_rd  in  5  destination register index
- i_rd_wen  in  1  destination write enable
- i_rd_wdata  in  64  destination write data
- i_intrNo  in  32  interrupt number; nonzero marks the cycle as interrupt, not a commit
- i_trap_code  in  8  a0[7:0] at commit
- i_freeze  in  1  level; forces HALT
- i_clear  in  1  pulse; empties buffer, returns to RUN
- i_rd_ready  in  1  drain-side ready
- o_rd_valid  out  1  head entry available
- o_rd_pc  out  64  head pc
- o_rd_inst  out  32  head instruction
- o_rd_wen  out  1  head rd write enable
- o_rd_wdest  out  5  head rd index
- o_rd_wdata  out  64  head rd data
- o_rd_skip  out  1  head skip flag
- o_count  out  AW+1  entries held
- o_overflow  out  1  sticky: at least one entry was overwritten
- o_halted  out  1  state is HALT
- o_trap  out  1  sticky: trap was captured
- o_trap_code  out  8  code latched with the trap
- o_trap_pc  out  64  pc of the trap instruction
- o_cycle_cnt  out  64  cycles spent in RUN
- o_instr_cnt  out  64  commits captured since reset

Behaviour:
- Reset:
  - State RUN; write/read pointers 0; count 0.
  - o_overflow, o_trap, o_trap_code, o_trap_pc, o_cycle_cnt, o_instr_cnt all 0.
  - o_rd_valid 0. The storage array is not reset.
- Capture condition: state==RUN and i_cmtvalid and i_intrNo==0. Cycles with nonzero i_intrNo are never captured.
- On capture at the rising edge:
  - The entry {pc, inst, rd_wen, rd, wdata, skip} is written at wptr; wptr increments and wraps mod DEPTH.
  - o_instr_cnt increments.
  - If count < DEPTH, count increments.
  - If count == DEPTH, rptr also increments (oldest entry discarded) and o_overflow is set. Count stays DEPTH.
- o_cycle_cnt increments every cycle in RUN and holds in HALT.
- Trap: a captured commit with i_inst[6:0]==7'h6b:
  - The entry itself is stored.
  - o_trap is set; o_trap_code = i_trap_code; o_trap_pc = i_pc.
  - State becomes HALT on the same edge; o_halted=1 on the next cycle.
- Freeze: i_freeze=1 in RUN moves the state to HALT at the edge. A commit presented in that same cycle is still captured.
- FSM:
  - RUN -> HALT on trap or i_freeze.
  - HALT -> RUN on i_clear.
  - RUN + i_clear stays RUN and flushes.
- Drain port:
  - o_rd_valid = (state==HALT) and (count != 0). It is always 0 in RUN.
  - o_rd_* are driven combinationally from the entry at rptr (show-ahead).
  - A pop happens when o_rd_valid and i_rd_ready: rptr increments (wraps), count decrements.
  - o_rd_* values are don't-care when o_rd_valid=0.
- i_clear, in any state:
  - Sets pointers and count to 0; clears o_overflow, o_trap, o_trap_code, o_trap_pc.
  - State becomes RUN, except that if i_freeze is also 1 the state becomes HALT.
  - Counters o_cycle_cnt and o_instr_cnt are not cleared.
- Priority within one cycle: rst > i_clear > capture/pop.
  - A commit or pop in the same cycle as i_clear is dropped.
  - A trap in the same cycle as i_clear is lost.
- Pointer arithmetic is mod DEPTH. Count is AW+1 bits and ranges 0..DEPTH. Counters wrap at 2^64.

Test Plan:
- Reset, then 5 commits at pc 0x80000000+4k, then a freeze: o_count=5, o_halted=1. Draining with i_rd_ready=1 returns pc 0x80000000..0x80000010 in order, one per cycle; o_rd_valid drops after the 5th pop.
- DEPTH=16, 20 commits with pc=k, then freeze: o_count=16, o_overflow=1. The first pop returns pc 4 and the last returns pc 19.
- Trap commit inst=0x0000006b, pc=0x80000100, i_trap_code=0x00 after 3 normal commits: o_trap=1, o_trap_pc=0x80000100, o_count=4, o_halted=1. A following commit is not captured; o_cycle_cnt stays frozen.
- Commit with i_intrNo=7, then a normal commit: only the normal commit is stored; o_instr_cnt +1.
- Hold i_rd_ready=0 for 3 cycles in HALT with 2 entries: o_rd_valid stays 1 and the head data is stable. Toggle ready on alternate cycles: the 2 pops occur on the ready cycles only.
- i_clear in HALT with 6 entries, with a commit presented in the same cycle: next cycle o_count=0, o_overflow=0, o_trap=0, state RUN; that commit was not captured, and o_instr_cnt keeps its previous value.
